norm_shift_ctrl: RTL and testbench

- Iterative mantissa normalizer for the FP datapath (adder/subtractor post-cancellation path).
- Sequences one shared left barrel shifter (SHF_left, SIZE_DATA=SIZE_MAN, SIZE_SHIFT=SIZE_STEP) over several cycles, shifting at most 2^SIZE_STEP-1 bits per pass.
- Each pass decrements the exponent until the mantissa MSB is set, the mantissa is zero, or the exponent floor (subnormal) is reached.
- Valid/ready handshake on both sides; one operation in flight.

---
 rtl/norm_shift_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_norm_shift_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/norm_shift_ctrl.sv
// norm_shift_ctrl: iterative mantissa normalizer for the FP add/sub
// post-cancellation path. A single left barrel shifter is reused over
// several cycles. Each pass shifts at most MAX_STEP bits and lowers the
// exponent by the same amount. Iteration stops when the mantissa MSB is set,
// when the mantissa is zero, or when the exponent reaches its floor
// (subnormal result).

// Left barrel shifter: SIZE_SHIFT binary-weighted stages, zero fill.
module SHF_left #(
  parameter int SIZE_DATA  = 24,
  parameter int SIZE_SHIFT = 3
) (
  input  logic [SIZE_DATA-1:0]  data,
  input  logic [SIZE_SHIFT-1:0] shift,
  output logic [SIZE_DATA-1:0]  result
);

  logic [SIZE_DATA-1:0] stage [0:SIZE_SHIFT];

  assign stage[0] = data;

  generate
    for (genvar gi = 0; gi < SIZE_SHIFT; gi++) begin : g_stage
      // Stage gi shifts by 2^gi when its select bit is set.
      assign stage[gi+1] = shift[gi] ? (stage[gi] << (1 << gi)) : stage[gi];
    end
  endgenerate

  assign result = stage[SIZE_SHIFT];

endmodule

module norm_shift_ctrl #(
  parameter int SIZE_MAN  = 24,
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_STEP = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [SIZE_MAN-1:0] i_mantissa,
  input  logic [SIZE_EXP-1:0] i_exponent,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZE_MAN-1:0] o_mantissa,
  output logic [SIZE_EXP-1:0] o_exponent,
  output logic                o_zero,
  output logic                o_denorm,
  output logic                o_busy
);

  localparam int MAX_STEP = (1 << SIZE_STEP) - 1;
  localparam int LZ_W     = $clog2(SIZE_MAN + 1);
  // Common width used when comparing lz, MAX_STEP and allowed.
  localparam int CW       = (SIZE_EXP + 1 > LZ_W) ? SIZE_EXP + 1 : LZ_W;
  localparam logic [SIZE_EXP:0] ONE_EXT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [SIZE_MAN-1:0]  mant_reg;
  logic [SIZE_EXP-1:0]  exp_reg;
  logic                 zero_reg;
  logic                 denorm_reg;

  logic [LZ_W-1:0]      lz;
  logic [SIZE_EXP:0]    allowed;
  logic [SIZE_STEP-1:0] step;
  logic [SIZE_STEP-1:0] shift_sel;
  logic [SIZE_MAN-1:0]  shifted;
  logic                 mant_is_zero;
  logic                 is_norm;
  logic                 at_floor;

  SHF_left #(
    .SIZE_DATA  (SIZE_MAN),
    .SIZE_SHIFT (SIZE_STEP)
  ) u_shf (
    .data   (mant_reg),
    .shift  (shift_sel),
    .result (shifted)
  );

  // Leading-zero count of the working mantissa. The highest set bit is
  // written last, so it wins. An all-zero value reads as SIZE_MAN.
  always_comb begin
    lz = LZ_W'(SIZE_MAN);
    for (int i = 0; i < SIZE_MAN; i++) begin
      if (mant_reg[i]) lz = LZ_W'(SIZE_MAN - 1 - i);
    end
  end

  // Shift budget that keeps the exponent >= 1. It is one bit wider than
  // the exponent and clamps at zero, so it cannot wrap.
  always_comb begin
    allowed = '0;
    if (exp_reg != '0) allowed = {1'b0, exp_reg} - ONE_EXT;
  end

  // step = min(lz, MAX_STEP, allowed). These are the termination
  // conditions for the SHIFT state.
  always_comb begin
    logic [CW-1:0] min_v;
    min_v = CW'(lz);
    if (CW'(MAX_STEP) < min_v) min_v = CW'(MAX_STEP);
    if (CW'(allowed) < min_v)  min_v = CW'(allowed);
    step         = SIZE_STEP'(min_v);
    mant_is_zero = (mant_reg == '0);
    is_norm      = mant_reg[SIZE_MAN-1];
    at_floor     = (allowed == '0);
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_valid) state_next = SHIFT;
      SHIFT:   if (mant_is_zero || is_norm || at_floor) state_next = DONE;
      DONE:    if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs. The shifter select is held at zero outside SHIFT.
  always_comb begin
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b1;
    shift_sel = '0;
    case (state_reg)
      IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
      end
      SHIFT:   shift_sel = step;
      DONE:    o_valid = 1'b1;
      default: o_busy = 1'b0;
    endcase
  end

  // Datapath: capture the operand on accept, then iterate the shift in
  // SHIFT. Checks are in priority order: zero, normalized, floor, shift.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mant_reg   <= '0;
      exp_reg    <= '0;
      zero_reg   <= 1'b0;
      denorm_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            mant_reg   <= i_mantissa;
            exp_reg    <= i_exponent;
            zero_reg   <= 1'b0;
            denorm_reg <= 1'b0;
          end
        end
        SHIFT: begin
          if (mant_is_zero) begin
            zero_reg <= 1'b1;
            exp_reg  <= '0;
            mant_reg <= '0;
          end else if (is_norm) begin
            // Already normalized. Leave the exponent untouched, even at 0.
          end else if (at_floor) begin
            denorm_reg <= 1'b1;
            exp_reg    <= '0;
          end else begin
            mant_reg <= shifted;
            exp_reg  <= exp_reg - SIZE_EXP'(step);
          end
        end
        default: ;
      endcase
    end
  end

  // These registers stay stable through DONE, so they drive the result.
  assign o_mantissa = mant_reg;
  assign o_exponent = exp_reg;
  assign o_zero     = zero_reg;
  assign o_denorm   = denorm_reg;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Self-checking bench for norm_shift_ctrl: directed cases, backpressure,
// asynchronous reset mid-operation, and random operands checked against a
// closed-form normalization model.
`timescale 1ns/1ps

module tb_norm_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [23:0] i_mantissa;
  logic [7:0]  i_exponent;
  logic        o_valid;
  logic        i_ready;
  logic [23:0] o_mantissa;
  logic [7:0]  o_exponent;
  logic        o_zero;
  logic        o_denorm;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  norm_shift_ctrl #(.SIZE_MAN(24), .SIZE_EXP(8), .SIZE_STEP(3)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_mantissa (i_mantissa),
    .i_exponent (i_exponent),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_mantissa (o_mantissa),
    .o_exponent (o_exponent),
    .o_zero     (o_zero),
    .o_denorm   (o_denorm),
    .o_busy     (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Closed-form model. Normalize completely if the exponent budget
  // (exp-1) allows it. Otherwise spend the whole budget, set the exponent
  // to 0 and mark the result subnormal. Latency is ceil(shift/7) passes
  // plus one terminating edge.
  function automatic void model(input logic [23:0] m, input logic [7:0] e,
                                output logic [23:0] rm, output logic [7:0] re,
                                output logic rz, output logic rd, output int lat);
    int lz;
    int avail;
    rz = 1'b0; rd = 1'b0; rm = m; re = e; lat = 1;
    if (m == 24'd0) begin
      rz = 1'b1; rm = '0; re = '0; lat = 1;
      return;
    end
    lz = 0;
    while (!m[23-lz]) lz++;
    avail = (e >= 8'd1) ? int'(e) - 1 : 0;
    if (lz <= avail) begin
      rm  = m << lz;
      re  = e - 8'(lz);
      lat = (lz + 6) / 7 + 1;
    end else begin
      rm  = m << avail;
      re  = '0;
      rd  = 1'b1;
      lat = (avail + 6) / 7 + 1;
    end
  endfunction

  // One transaction: offer, wait for result, check, optionally hold with
  // backpressure (poking a stray i_valid), then release.
  task automatic run_op(input logic [23:0] m, input logic [7:0] e,
                        input int hold, input bit poke);
    logic [23:0] rm;
    logic [7:0]  re;
    logic        rz, rd;
    int          lat, n;
    model(m, e, rm, re, rz, rd, lat);
    @(negedge clk);
    check("ready_idle", 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_mantissa = m; i_exponent = e;
    @(negedge clk);
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("mantissa", 32'(o_mantissa), 32'(rm));
    check("exponent", 32'(o_exponent), 32'(re));
    check("zero", 32'(o_zero), 32'(rz));
    check("denorm", 32'(o_denorm), 32'(rd));
    check("ready_done", 32'(o_ready), 32'd0);
    check("busy_done", 32'(o_busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        i_valid    = 1'b1;
        i_mantissa = 24'($urandom);
        i_exponent = 8'($urandom);
      end
      @(negedge clk);
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_ready", 32'(o_ready), 32'd0);
      check("hold_mant", 32'(o_mantissa), 32'(rm));
      check("hold_exp", 32'(o_exponent), 32'(re));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check("release_valid", 32'(o_valid), 32'd0);
    check("release_ready", 32'(o_ready), 32'd1);
    $display("op mant=%06h exp=%0d -> mant=%06h exp=%0d zero=%0d denorm=%0d lat=%0d hold=%0d",
             m, e, o_mantissa, o_exponent, o_zero, o_denorm, n, hold);
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_mantissa = '0; i_exponent = '0;
    #12;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_mant", 32'(o_mantissa), 32'd0);
    check("rst_exp", 32'(o_exponent), 32'd0);
    check("rst_flags", 32'({o_zero, o_denorm}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op(24'h000001, 8'd100, 0, 1'b0);
    run_op(24'h800000, 8'd5,   0, 1'b0);
    run_op(24'h000000, 8'd50,  0, 1'b0);
    run_op(24'h001000, 8'd4,   0, 1'b0);
    run_op(24'h400000, 8'd0,   0, 1'b0);
    run_op(24'h800000, 8'd0,   0, 1'b0);
    run_op(24'h000800, 8'd12,  0, 1'b0);

    // Backpressure with a stray i_valid, then a fresh operand.
    run_op(24'h000001, 8'd100, 3, 1'b1);
    run_op(24'h000300, 8'd40,  0, 1'b0);

    // Async reset mid-SHIFT, asserted between clock edges.
    @(negedge clk);
    i_valid = 1'b1; i_mantissa = 24'h000001; i_exponent = 8'd100;
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(posedge clk);
    #1 check("pre_rst_busy", 32'(o_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_ready", 32'(o_ready), 32'd1);
    check("arst_mant", 32'(o_mantissa), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(24'h000001, 8'd100, 0, 1'b0);

    // Random operands with varied leading-zero counts and small exponents.
    for (int k = 0; k < 40; k++) begin
      logic [23:0] m;
      logic [7:0]  e;
      m = 24'($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) m = '0;
      e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      run_op(m, e, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
